raw_window_3x3: RTL and testbench

- Streaming 3x3 neighbourhood generator for raw Bayer pixels.
- Sits directly upstream of the demosaic arithmetic.
- Two line memories (1-read/1-write, 1-cycle read latency) hold the previous two image rows.
- Each accepted pixel yields a registered 3x3 window, the window-centre coordinates and the Bayer phase.

---
 rtl/raw_pkg.sv | 38 +++
 rtl/raw_line_mem.sv | 50 +++++
 rtl/raw_window_3x3.sv | 236 +++++++++++++++++++++++
 tb/tb_raw_window_3x3.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/raw_pkg.sv
// -----------------------------------------------------------------------------
// raw_pkg
// Shared definitions for the raw 3x3 window generator:
//   - Bayer phase encoding for a RGGB mosaic, indexed by {row lsb, col lsb}
//   - FSM state enum for frame tracking
//   - Tap geometry of the 3x3 window (centre tap is TAP_C)
// No ports (package).
// -----------------------------------------------------------------------------
package raw_pkg;

  localparam logic [1:0] RGGB_R  = 2'b00;
  localparam logic [1:0] RGGB_GR = 2'b01;
  localparam logic [1:0] RGGB_GB = 2'b10;
  localparam logic [1:0] RGGB_B  = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int TAP_ROWS = 3;
  localparam int TAP_COLS = 3;
  localparam int TAP_C    = 4;
  localparam int NTAPS    = 2 * TAP_C + 1;

  // Names the mosaic colour at a window centre from the coordinate lsbs.
  function automatic logic [1:0] bayer_phase(input logic y_lsb, input logic x_lsb);
    logic [1:0] ph;
    unique case ({y_lsb, x_lsb})
      2'b00:   ph = RGGB_R;
      2'b01:   ph = RGGB_GR;
      2'b10:   ph = RGGB_GB;
      default: ph = RGGB_B;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/raw_line_mem.sv
// -----------------------------------------------------------------------------
// raw_line_mem
// One-write/one-read line memory with a registered (1-cycle) read port.
// A read and a write in the same cycle return the pre-write contents.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset, clears contents and read data
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data updates only when set
//   rd_addr  in   read address
//   rd_data  out  registered read data
// -----------------------------------------------------------------------------
module raw_line_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 640,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/raw_window_3x3.sv
// -----------------------------------------------------------------------------
// raw_window_3x3
// Streaming 3x3 neighbourhood generator for raw Bayer pixels. Two line
// memories hold the previous two rows; each accepted pixel with x>=2, y>=2
// yields one registered window two clock edges after it was sampled, with the
// window centre at (x-1, y-1). No border replication.
// Optional feature (macro RAW_FRAME_ERR_EN): adds frame_err, a one-cycle pulse
// for short frames (sof while active) and long frames (pixels after a
// completed frame before the next sof).
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   pixel strobe, gaps allowed, no backpressure
//   in_sof     in   start of frame, qualified by in_valid
//   in_data    in   raw pixel
//   win_valid  out  one-cycle window strobe
//   win_data   out  taps, tap (r,c) at [(r*3+c)*WIDTH +: WIDTH], r=0 oldest row
//   win_x      out  centre column
//   win_y      out  centre row
//   win_phase  out  {win_y[0], win_x[0]}
//   frame_err  out  framing error pulse (RAW_FRAME_ERR_EN only)
// -----------------------------------------------------------------------------
module raw_window_3x3
  import raw_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     win_valid,
  output logic [NTAPS*WIDTH-1:0]   win_data,
  output logic [$clog2(IMG_W)-1:0] win_x,
  output logic [$clog2(IMG_H)-1:0] win_y,
  output logic [1:0]               win_phase
`ifdef RAW_FRAME_ERR_EN
  ,
  output logic                     frame_err
`endif
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  // ---------------------------------------------------------------------------
  // Frame tracking FSM and coordinate counters
  // ---------------------------------------------------------------------------
  state_t          state_reg, state_next;
  logic [XW-1:0]   x_reg, x_next, cur_x;
  logic [YW-1:0]   y_reg, y_next, cur_y;
  logic            accept;
  logic            last_col, last_row;

  always_comb begin
    // sof always restarts at (0,0), whatever the current state
    accept     = in_valid && (in_sof || (state_reg == ACTIVE));
    cur_x      = in_sof ? '0 : x_reg;
    cur_y      = in_sof ? '0 : y_reg;
    last_col   = (cur_x == XW'(IMG_W - 1));
    last_row   = (cur_y == YW'(IMG_H - 1));
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    if (accept) begin
      if (last_col) begin
        x_next = '0;
        if (last_row) begin
          y_next     = '0;
          state_next = IDLE;
        end else begin
          y_next     = cur_y + 1'b1;
          state_next = ACTIVE;
        end
      end else begin
        x_next     = cur_x + 1'b1;
        y_next     = cur_y;
        state_next = ACTIVE;
      end
    end
  end

  // Stage A: the accepted pixel and its coordinates, aligned with the
  // registered line-memory read data.
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic [XW-1:0]    a_x;
  logic [YW-1:0]    a_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      a_valid   <= 1'b0;
      a_data    <= '0;
      a_x       <= '0;
      a_y       <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      a_valid   <= accept;
      if (accept) begin
        a_data <= in_data;
        a_x    <= cur_x;
        a_y    <= cur_y;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line memories: read at the accept cycle, written one cycle later. LINE1
  // takes LINE0's old value, so the pair acts as a two-row shift at column x.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] line0_rd, line1_rd;

  raw_line_mem #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_line0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (a_valid),
    .wr_addr (a_x),
    .wr_data (a_data),
    .rd_en   (accept),
    .rd_addr (cur_x),
    .rd_data (line0_rd)
  );

  raw_line_mem #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_line1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (a_valid),
    .wr_addr (a_x),
    .wr_data (line0_rd),
    .rd_en   (accept),
    .rd_addr (cur_x),
    .rd_data (line1_rd)
  );

  // ---------------------------------------------------------------------------
  // Stage B: window shift register. The new column enters at c=2.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] col [TAP_ROWS];
  logic [WIDTH-1:0] window_reg  [NTAPS];
  logic [WIDTH-1:0] window_next [NTAPS];

  assign col[0] = line1_rd;  // row y-2
  assign col[1] = line0_rd;  // row y-1
  assign col[2] = a_data;    // row y

  for (genvar gi = 0; gi < TAP_ROWS; gi++) begin : g_row
    localparam int T0 = gi * TAP_COLS;
    assign window_next[T0 + 0] = window_reg[T0 + 1];
    assign window_next[T0 + 1] = window_reg[T0 + 2];
    assign window_next[T0 + 2] = col[gi];
  end

  // Columns that straddle a line wrap are still shifted in; the x>=2 test
  // keeps them from ever being published.
  logic          a_qual;
  logic          b_valid;
  logic [XW-1:0] b_x;
  logic [YW-1:0] b_y;

  assign a_qual = a_valid && (a_x >= XW'(2)) && (a_y >= YW'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        window_reg[i] <= '0;
      end
      b_valid <= 1'b0;
      b_x     <= '0;
      b_y     <= '0;
    end else begin
      b_valid <= a_qual;
      if (a_valid) begin
        window_reg <= window_next;
      end
      if (a_qual) begin
        b_x <= a_x - 1'b1;
        b_y <= a_y - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage C: output registers, loaded only for published windows so that all
  // window outputs hold between pulses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_data  <= '0;
      win_x     <= '0;
      win_y     <= '0;
      win_phase <= '0;
    end else begin
      win_valid <= b_valid;
      if (b_valid) begin
        for (int i = 0; i < NTAPS; i++) begin
          win_data[i*WIDTH +: WIDTH] <= window_reg[i];
        end
        win_x     <= b_x;
        win_y     <= b_y;
        win_phase <= bayer_phase(b_y[0], b_x[0]);
      end
    end
  end

`ifdef RAW_FRAME_ERR_EN
  // done_reg remembers that the last frame finished, so stray pixels before
  // the next sof can be flagged as a long frame.
  logic done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_reg  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= in_valid &&
                   ((in_sof && (state_reg == ACTIVE)) ||
                    (!in_sof && (state_reg == IDLE) && done_reg));
      if (in_valid && in_sof) begin
        done_reg <= 1'b0;
      end else if (accept && last_col && last_row) begin
        done_reg <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_raw_window_3x3.sv
// -----------------------------------------------------------------------------
// tb_raw_window_3x3
// Directed bench for raw_window_3x3 with an 8x6 image, pixel = base+y*16+x.
// Expected windows are derived from the raster position of each driven pixel.
// -----------------------------------------------------------------------------
module tb_raw_window_3x3;

  localparam int W  = 8;
  localparam int IW = 8;
  localparam int IH = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          win_valid;
  logic [71:0]   win_data;
  logic [2:0]    win_x;
  logic [2:0]    win_y;
  logic [1:0]    win_phase;
`ifdef RAW_FRAME_ERR_EN
  logic          frame_err;
`endif

  always #5 clk = ~clk;

  raw_window_3x3 #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .win_valid (win_valid),
    .win_data  (win_data),
    .win_x     (win_x),
    .win_y     (win_y),
    .win_phase (win_phase)
`ifdef RAW_FRAME_ERR_EN
    ,
    .frame_err (frame_err)
`endif
  );

  typedef struct packed {
    int          cyc;
    logic [2:0]  x;
    logic [2:0]  y;
    logic [1:0]  ph;
    logic [71:0] data;
  } win_t;

  win_t exp_q[$];
  win_t got_q[$];
  win_t mon_w;
  int   pe = 0;
  int   checks = 0;
  int   failures = 0;
  int   err_cnt = 0;

  always @(posedge clk) pe <= pe + 1;

  always @(negedge clk) begin
    if (win_valid === 1'b1) begin
      mon_w.cyc  = pe;
      mon_w.x    = win_x;
      mon_w.y    = win_y;
      mon_w.ph   = win_phase;
      mon_w.data = win_data;
      got_q.push_back(mon_w);
      $display("win cyc=%0d centre=(%0d,%0d) ph=%0d data=%h", pe, win_x, win_y, win_phase, win_data);
    end
`ifdef RAW_FRAME_ERR_EN
    if (frame_err === 1'b1) err_cnt++;
`endif
  end

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  // Drives npix pixels of a frame in raster order (sof on the first) and
  // queues the window each qualifying pixel must produce two edges later.
  task automatic send_frame(input int base, input bit gaps, input int npix);
    win_t e;
    for (int k = 0; k < npix; k++) begin
      int x = k % IW;
      int y = k / IW;
      drive(1'b1, (k == 0), 8'(base + y * 16 + x));
      if (x >= 2 && y >= 2) begin
        e.cyc = pe + 2;
        e.x   = 3'(x - 1);
        e.y   = 3'(y - 1);
        e.ph  = {e.y[0], e.x[0]};
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e.data[(r*3+c)*8 +: 8] = 8'(base + (y - 2 + r) * 16 + (x - 2 + c));
        exp_q.push_back(e);
      end
      if (gaps) drive(1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL reset_win_valid got=%0b exp=0", win_valid); end
    checks++; if (win_data !== 72'h0) begin failures++; $display("FAIL reset_win_data got=%h exp=0", win_data); end
    checks++; if (win_x !== 3'd0) begin failures++; $display("FAIL reset_win_x got=%0d exp=0", win_x); end
    checks++; if (win_y !== 3'd0) begin failures++; $display("FAIL reset_win_y got=%0d exp=0", win_y); end
    checks++; if (win_phase !== 2'd0) begin failures++; $display("FAIL reset_win_phase got=%0d exp=0", win_phase); end
`ifdef RAW_FRAME_ERR_EN
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%0b exp=0", frame_err); end
`endif
    rst = 1'b0;
    idle(2);
    checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_valid got=%0b exp=0", win_valid); end
    $display("test_reset done");
  endtask

  task automatic test_no_sof();
    int e0 = err_cnt;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'(8'hE0 + i));
    send_frame(0, 1'b0, IW * IH);
    idle(6);
    checks++; if (got_q.size() != 24) begin failures++; $display("FAIL nosof_count got=%0d exp=24", got_q.size()); end
    checks++;
    if (got_q.size() == 0 || got_q[0].x !== 3'd1 || got_q[0].y !== 3'd1 || got_q[0].data[4*8 +: 8] !== 8'h11) begin
      failures++; $display("FAIL nosof_first got x=%0d y=%0d centre=%h exp x=1 y=1 centre=11", got_q[0].x, got_q[0].y, got_q[0].data[4*8 +: 8]);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL nosof_win%0d got cyc=%0d x=%0d y=%0d data=%h exp cyc=%0d x=%0d y=%0d data=%h", i, got_q[i].cyc, got_q[i].x, got_q[i].y, got_q[i].data, exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].data); end
    end
`ifdef RAW_FRAME_ERR_EN
    checks++; if (err_cnt - e0 != 0) begin failures++; $display("FAIL nosof_frame_err got=%0d exp=0", err_cnt - e0); end
`endif
    $display("test_no_sof done");
  endtask

  task automatic test_continuous();
    int e0 = err_cnt;
    exp_q.delete(); got_q.delete();
    send_frame(0, 1'b0, IW * IH);
    idle(6);
    checks++; if (got_q.size() != 24) begin failures++; $display("FAIL cont_count got=%0d exp=24", got_q.size()); end
    checks++;
    if (got_q.size() == 0 || got_q[0].data !== 72'h22_21_20_12_11_10_02_01_00 || got_q[0].x !== 3'd1 || got_q[0].y !== 3'd1 || got_q[0].ph !== 2'b11) begin
      failures++; $display("FAIL cont_first got x=%0d y=%0d ph=%0d data=%h exp x=1 y=1 ph=3 data=222120121110020100", got_q[0].x, got_q[0].y, got_q[0].ph, got_q[0].data);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL cont_win%0d got cyc=%0d x=%0d y=%0d ph=%0d data=%h exp cyc=%0d x=%0d y=%0d ph=%0d data=%h", i, got_q[i].cyc, got_q[i].x, got_q[i].y, got_q[i].ph, got_q[i].data, exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].ph, exp_q[i].data); end
    end
`ifdef RAW_FRAME_ERR_EN
    checks++; if (err_cnt - e0 != 0) begin failures++; $display("FAIL cont_frame_err got=%0d exp=0", err_cnt - e0); end
`endif
    $display("test_continuous done");
  endtask

  task automatic test_gaps();
    exp_q.delete(); got_q.delete();
    send_frame(0, 1'b1, IW * IH);
    idle(6);
    checks++; if (got_q.size() != 24) begin failures++; $display("FAIL gaps_count got=%0d exp=24", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL gaps_win%0d got cyc=%0d x=%0d y=%0d data=%h exp cyc=%0d x=%0d y=%0d data=%h", i, got_q[i].cyc, got_q[i].x, got_q[i].y, got_q[i].data, exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].data); end
    end
    $display("test_gaps done");
  endtask

  task automatic test_back_to_back();
    int e0 = err_cnt;
    exp_q.delete(); got_q.delete();
    send_frame(0, 1'b0, IW * IH);
    send_frame(128, 1'b0, IW * IH);
    idle(6);
    checks++; if (got_q.size() != 48) begin failures++; $display("FAIL b2b_count got=%0d exp=48", got_q.size()); end
    checks++;
    if (got_q.size() < 25 || got_q[24].x !== 3'd1 || got_q[24].y !== 3'd1 || got_q[24].data[4*8 +: 8] !== 8'h91) begin
      failures++; $display("FAIL b2b_first2 got x=%0d y=%0d centre=%h exp x=1 y=1 centre=91", got_q[24].x, got_q[24].y, got_q[24].data[4*8 +: 8]);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_win%0d got cyc=%0d x=%0d y=%0d data=%h exp cyc=%0d x=%0d y=%0d data=%h", i, got_q[i].cyc, got_q[i].x, got_q[i].y, got_q[i].data, exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].data); end
    end
`ifdef RAW_FRAME_ERR_EN
    checks++; if (err_cnt - e0 != 0) begin failures++; $display("FAIL b2b_frame_err got=%0d exp=0", err_cnt - e0); end
`endif
    $display("test_back_to_back done");
  endtask

  task automatic test_mid_sof();
    int e0 = err_cnt;
    exp_q.delete(); got_q.delete();
    // Pixels (0,0)..(2,4); the next pixel, at (3,4), carries sof.
    send_frame(0, 1'b0, 4 * IW + 3);
    send_frame(64, 1'b0, IW * IH);
    idle(6);
    checks++; if (got_q.size() != 37) begin failures++; $display("FAIL midsof_count got=%0d exp=37", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL midsof_win%0d got cyc=%0d x=%0d y=%0d data=%h exp cyc=%0d x=%0d y=%0d data=%h", i, got_q[i].cyc, got_q[i].x, got_q[i].y, got_q[i].data, exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].data); end
    end
`ifdef RAW_FRAME_ERR_EN
    checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL midsof_frame_err got=%0d exp=1", err_cnt - e0); end
`endif
    $display("test_mid_sof done");
  endtask

  task automatic test_reset_mid();
    exp_q.delete(); got_q.delete();
    // Pixels up to and including (5,3); its window must never appear.
    send_frame(0, 1'b0, 3 * IW + 6);
    void'(exp_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0b exp=0", win_valid); end
    checks++; if (win_data !== 72'h0) begin failures++; $display("FAIL rstmid_data got=%h exp=0", win_data); end
    checks++; if ({win_x, win_y, win_phase} !== 8'h00) begin failures++; $display("FAIL rstmid_coord got x=%0d y=%0d ph=%0d exp 0 0 0", win_x, win_y, win_phase); end
    @(posedge clk);
    #1;
    checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL rstmid_pending got=%0b exp=0", win_valid); end
    rst = 1'b0;
    idle(6);
    checks++; if (got_q.size() != 9) begin failures++; $display("FAIL rstmid_count got=%0d exp=9", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rstmid_win%0d got cyc=%0d x=%0d y=%0d data=%h exp cyc=%0d x=%0d y=%0d data=%h", i, got_q[i].cyc, got_q[i].x, got_q[i].y, got_q[i].data, exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].data); end
    end
    exp_q.delete(); got_q.delete();
    send_frame(0, 1'b0, IW * IH);
    idle(6);
    checks++; if (got_q.size() != 24) begin failures++; $display("FAIL rstmid_next_count got=%0d exp=24", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rstmid_next_win%0d got cyc=%0d x=%0d y=%0d data=%h exp cyc=%0d x=%0d y=%0d data=%h", i, got_q[i].cyc, got_q[i].x, got_q[i].y, got_q[i].data, exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].data); end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_no_sof();
    test_continuous();
    test_gaps();
    test_back_to_back();
    test_mid_sof();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
